// File: rtl/pwm_audio_pkg.sv
// rtl/pwm_audio_pkg.sv - shared types and default widths for the PWM audio blocks
package pwm_audio_pkg;

  // Default counter width; also the generator's frequency width.
  localparam int PWM_CNT_W    = 16;
  // Default PCM sample width; also the number of divider iterations.
  localparam int PWM_SAMPLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } demod_state_e;

endpackage

// File: rtl/pwm_div_seq.sv
// rtl/pwm_div_seq.sv - restoring divider, one quotient bit per cycle, quot = floor(num*2^SAMPLE_W/den)
module pwm_div_seq
  import pwm_audio_pkg::*;
#(
  parameter int CNT_W    = PWM_CNT_W,
  parameter int SAMPLE_W = PWM_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num,
  input  logic [CNT_W-1:0]    den,
  output logic                busy,
  output logic                done,
  output logic [SAMPLE_W-1:0] quot
);

  localparam int IT_W = $clog2(SAMPLE_W + 1);

  logic [CNT_W:0]      rem;
  logic [CNT_W-1:0]    den_q;
  logic [SAMPLE_W-1:0] quot_q;
  logic [IT_W-1:0]     it;

  logic [CNT_W:0]      rem_src;
  logic [CNT_W:0]      den_ext;
  logic [CNT_W:0]      shifted;
  logic [CNT_W:0]      diff;
  logic                q_bit;

  // it counts completed iterations; the first one is folded into the start cycle
  assign busy = (it != '0);
  assign done = (it == IT_W'(SAMPLE_W));
  assign quot = quot_q;

  // One restoring step, fed from the operands directly on start so no cycle is lost
  always_comb begin
    rem_src = busy ? rem : {1'b0, num};
    den_ext = busy ? {1'b0, den_q} : {1'b0, den};
    shifted = rem_src << 1;
    q_bit   = (shifted >= den_ext);
    diff    = shifted - den_ext;
  end

  // Iteration state; the done cycle performs no step and frees the divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem    <= '0;
      den_q  <= '0;
      quot_q <= '0;
      it     <= '0;
    end else if (busy) begin
      if (done) begin
        it <= '0;
      end else begin
        rem    <= q_bit ? diff : shifted;
        quot_q <= {quot_q[SAMPLE_W-2:0], q_bit};
        it     <= it + IT_W'(1);
      end
    end else if (start) begin
      rem    <= q_bit ? diff : shifted;
      den_q  <= den;
      quot_q <= SAMPLE_W'(q_bit);
      it     <= IT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_demod.sv
// rtl/pwm_demod.sv - PWM duty-cycle demodulator producing PCM samples on a valid/ready stream
module pwm_demod
  import pwm_audio_pkg::*;
#(
  parameter int CNT_W    = PWM_CNT_W,
  parameter int SAMPLE_W = PWM_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_i,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic [CNT_W-1:0]    period_o,
  output logic [CNT_W-1:0]    high_o,
  output logic                timeout_o,
  output logic                overrun_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sync1, sync2, sync_d;
  logic rise, fall;

  demod_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, hi_q;

  logic cnt_load, cnt_inc, hi_load, capture, tmo, tmo_full;
  logic cap_ok, cap_drop;

  logic                div_busy, div_done;
  logic [SAMPLE_W-1:0] div_quot;

  logic                res_valid, res_clash, accept, out_drop;
  logic [SAMPLE_W-1:0] res_data;

  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync_d;
  assign fall = ~sync2 & sync_d;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; a saturated counter wins over a coincident edge
  always_comb begin
    state_nxt = state;
    if (!enable_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rise) state_nxt = ST_HIGH;
        ST_HIGH: begin
          if (cnt == CNT_MAX) state_nxt = ST_IDLE;
          else if (fall)      state_nxt = ST_LOW;
        end
        ST_LOW: begin
          if (cnt == CNT_MAX) state_nxt = ST_IDLE;
          else if (rise)      state_nxt = ST_HIGH;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: counter control, high-time latch, period capture and timeout
  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    hi_load  = 1'b0;
    capture  = 1'b0;
    tmo      = 1'b0;
    tmo_full = 1'b0;
    if (enable_i) begin
      case (state)
        ST_IDLE: cnt_load = rise;
        ST_HIGH: begin
          if (cnt == CNT_MAX) begin
            tmo      = 1'b1;
            tmo_full = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            hi_load = fall;
          end
        end
        ST_LOW: begin
          if (cnt == CNT_MAX) begin
            tmo = 1'b1;
          end else if (rise) begin
            capture  = 1'b1;
            cnt_load = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Shared high/period counter and the latched high time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      hi_q <= '0;
    end else begin
      if (cnt_load)     cnt <= CNT_W'(1);
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (hi_load) hi_q <= cnt;
    end
  end

  // A period closing while the divider still works on the previous one is dropped
  assign cap_ok   = capture & ~div_busy;
  assign cap_drop = capture & div_busy;

  pwm_div_seq #(
    .CNT_W    (CNT_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (cap_ok),
    .num   (hi_q),
    .den   (cnt),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  // Last accepted measurement and the sticky timeout level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_o    <= '0;
      period_o  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (cap_ok) begin
        high_o   <= hi_q;
        period_o <= cnt;
      end
      if (tmo)         timeout_o <= 1'b1;
      else if (cap_ok) timeout_o <= 1'b0;
    end
  end

  // Divider results take the output slot; a coincident synthetic sample is lost
  assign res_valid = div_done | tmo;
  assign res_clash = div_done & tmo;
  assign res_data  = div_done ? div_quot : (tmo_full ? {SAMPLE_W{1'b1}} : '0);
  assign accept    = sample_valid_o & sample_ready_i;
  assign out_drop  = res_valid & sample_valid_o & ~accept;

  // Output register with hold-until-accepted and a merged overrun pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      if (res_valid && (!sample_valid_o || accept)) begin
        sample_o       <= res_data;
        sample_valid_o <= 1'b1;
      end else if (accept) begin
        sample_valid_o <= 1'b0;
      end
      overrun_o <= cap_drop | out_drop | res_clash;
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// tb/tb_pwm_demod.sv - randomized self-checking bench for pwm_demod against a duty-cycle model
module tb_pwm_demod;

  localparam int CNT_W    = 16;
  localparam int SAMPLE_W = 8;
  localparam int SYNC_LAT = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable_i;
  logic                pwm_in;
  logic [SAMPLE_W-1:0] sample_o;
  logic                sample_valid_o;
  logic                sample_ready_i;
  logic [CNT_W-1:0]    period_o;
  logic [CNT_W-1:0]    high_o;
  logic                timeout_o;
  logic                overrun_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [SAMPLE_W-1:0] got_q[$];
  int n_ovr;
  int first_valid_cyc;
  logic valid_prev = 1'b0;

  pwm_demod #(.CNT_W(CNT_W), .SAMPLE_W(SAMPLE_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable_i),
    .pwm_in         (pwm_in),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .period_o       (period_o),
    .high_o         (high_o),
    .timeout_o      (timeout_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: accepted samples, first valid cycle, overrun pulses
  always @(negedge clk) begin
    if (sample_valid_o && !valid_prev && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (sample_valid_o && sample_ready_i) got_q.push_back(sample_o);
    if (overrun_o) n_ovr++;
    valid_prev = sample_valid_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_ovr = 0;
    first_valid_cyc = -1;
  endtask

  // Forces the FSM back to IDLE between scenarios
  task automatic gap();
    enable_i = 1'b0;
    repeat (2) tick();
    enable_i = 1'b1;
    repeat (2) tick();
  endtask

  // n periods of period p / high h; last_rise is the pad cycle of the final rise
  task automatic wave(input int p, input int h, input int n, output int last_rise);
    last_rise = -1;
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      last_rise = cyc;
      repeat (h) tick();
      pwm_in = 1'b0;
      repeat (p - h) tick();
    end
  endtask

  function automatic int model_sample(input int h, input int p);
    return (h * (1 << SAMPLE_W)) / p;
  endfunction

  initial begin
    int lr, p, h, k, n_acc, n_drop, last_start;
    int tp[3];
    int th[3];
    tp = '{100, 200, 3};
    th = '{25, 199, 1};

    reset = 1'b0;
    enable_i = 1'b1;
    pwm_in = 1'b0;
    sample_ready_i = 1'b1;
    clear_mon();
    repeat (3) tick();
    check_eq("rst_valid", sample_valid_o, 0);
    check_eq("rst_sample", sample_o, 0);
    check_eq("rst_period", period_o, 0);
    check_eq("rst_high", high_o, 0);
    check_eq("rst_timeout", timeout_o, 0);
    check_eq("rst_overrun", overrun_o, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Three periods of 256/64: first rise yields nothing, two samples follow
    clear_mon();
    wave(256, 64, 3, lr);
    repeat (20) tick();
    check_eq("d64_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("d64_s0", got_q[0], model_sample(64, 256));
      check_eq("d64_s1", got_q[1], model_sample(64, 256));
    end
    check_eq("d64_high", high_o, 64);
    check_eq("d64_period", period_o, 256);
    check_eq("d64_ovr", n_ovr, 0);

    // Table entries then random duty cycles, one closed period each
    for (int i = 0; i < 9; i++) begin
      if (i < 3) begin
        p = tp[i];
        h = th[i];
      end else begin
        p = $urandom_range(300, 2);
        h = $urandom_range(p - 1, 1);
      end
      gap();
      clear_mon();
      wave(p, h, 2, lr);
      repeat (20) tick();
      check_eq($sformatf("tbl%0d_count", i), got_q.size(), 1);
      if (got_q.size() > 0) check_eq($sformatf("tbl%0d_sample_p%0d_h%0d", i, p, h), got_q[0], model_sample(h, p));
      check_eq($sformatf("tbl%0d_high", i), high_o, h);
      check_eq($sformatf("tbl%0d_period", i), period_o, p);
      check_eq($sformatf("tbl%0d_latency", i), first_valid_cyc, lr + SYNC_LAT + SAMPLE_W + 1);
    end

    // Stuck high: timeout at full count, synthetic all-ones sample
    gap();
    clear_mon();
    pwm_in = 1'b1;
    k = cyc;
    repeat (65600) tick();
    check_eq("stuck_timeout", timeout_o, 1);
    check_eq("stuck_count", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("stuck_sample", got_q[0], (1 << SAMPLE_W) - 1);
    check_eq("stuck_latency", first_valid_cyc, k + SYNC_LAT + (1 << CNT_W) - 1 + 1);
    pwm_in = 1'b0;
    repeat (10) tick();
    check_eq("stuck_hold", timeout_o, 1);
    clear_mon();
    wave(256, 128, 2, lr);
    repeat (20) tick();
    check_eq("recover_timeout", timeout_o, 0);
    check_eq("recover_count", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("recover_sample", got_q[0], model_sample(128, 256));

    // Backpressure: first result held, later results dropped with overrun
    gap();
    clear_mon();
    sample_ready_i = 1'b0;
    wave(64, 16, 4, lr);
    repeat (20) tick();
    check_eq("bp_valid", sample_valid_o, 1);
    check_eq("bp_sample", sample_o, model_sample(16, 64));
    check_eq("bp_ovr", n_ovr, 2);
    check_eq("bp_count", got_q.size(), 0);
    check_eq("bp_high", high_o, 16);
    check_eq("bp_period", period_o, 64);
    sample_ready_i = 1'b1;
    tick();
    check_eq("bp_drop_valid", sample_valid_o, 0);
    check_eq("bp_acc_count", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("bp_acc_sample", got_q[0], model_sample(16, 64));

    // Short period: captures inside the divider's busy window are dropped
    gap();
    clear_mon();
    wave(4, 2, 8, lr);
    repeat (20) tick();
    n_acc = 0;
    n_drop = 0;
    last_start = -1000;
    for (int i = 0; i < 7; i++) begin
      if (4 * i - last_start > SAMPLE_W) begin
        n_acc++;
        last_start = 4 * i;
      end else begin
        n_drop++;
      end
    end
    check_eq("short_count", got_q.size(), n_acc);
    foreach (got_q[i]) check_eq($sformatf("short_s%0d", i), got_q[i], model_sample(2, 4));
    check_eq("short_ovr", n_ovr, n_drop);
    check_eq("short_high", high_o, 2);
    check_eq("short_period", period_o, 4);

    // Asynchronous reset in the middle of a high phase
    gap();
    pwm_in = 1'b1;
    repeat (5) tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_high", high_o, 0);
    check_eq("arst_period", period_o, 0);
    check_eq("arst_sample", sample_o, 0);
    check_eq("arst_valid", sample_valid_o, 0);
    check_eq("arst_timeout", timeout_o, 0);
    tick();
    pwm_in = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    clear_mon();
    wave(100, 50, 2, lr);
    repeat (20) tick();
    check_eq("arst_post_count", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("arst_post_sample", got_q[0], model_sample(50, 100));

    // Enable dropped mid-low: interrupted period produces no sample
    gap();
    clear_mon();
    pwm_in = 1'b1;
    repeat (30) tick();
    pwm_in = 1'b0;
    repeat (30) tick();
    enable_i = 1'b0;
    repeat (10) tick();
    enable_i = 1'b1;
    repeat (30) tick();
    wave(100, 30, 2, lr);
    repeat (20) tick();
    check_eq("en_count", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("en_sample", got_q[0], model_sample(30, 100));
    check_eq("en_ovr", n_ovr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_demod.md
Name: pwm_demod

Overview:
Receive-side counterpart to the PWM audio generator. Measures high time and period of an incoming PWM waveform on a GPIO pad and converts the duty cycle to a PCM sample. Delivers each sample on a valid/ready stream. Used for loopback self-test of the audio output and for capturing external PWM audio. Sits in the user project wrapper beside the generator, fed from an io_in bit with that pad's io_oeb held high.

Parameters:
CNT_W, 16, width of the high-time and period counters; also sets the timeout limit of 2^CNT_W-1 cycles.
SAMPLE_W, 8, width of the output sample and the number of divider iterations.

Ports:
clk  in  1  system clock (wb_clk_i in the wrapper)
reset  in  1  asynchronous, active-low reset
enable_i  in  1  measurement enable; low forces the FSM to IDLE
pwm_in  in  1  asynchronous PWM input from the pad
sample_o  out  SAMPLE_W  duty-cycle sample
sample_valid_o  out  1  sample_o valid
sample_ready_i  in  1  consumer accepts sample
period_o  out  CNT_W  last measured period, in cycles
high_o  out  CNT_W  last measured high time, in cycles
timeout_o  out  1  input stuck; held as a level
overrun_o  out  1  one-cycle pulse when a measurement is dropped

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, FSM goes to IDLE, synchronizer flops are 0.
- Input conditioning: 2-flop synchronizer, then a registered copy for edge detect. Rise = s & ~s_d; fall = ~s & s_d. Both edges are detected 2 cycles after the pad transition.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise, go to HIGH with cnt=1. The first rise after reset or enable produces no sample.
  - HIGH: cnt++ each cycle. On fall, hi=cnt and go to LOW.
  - LOW: cnt++ each cycle. On rise, the period is complete with per=cnt.
    - Capture hi and per into high_o and period_o.
    - Start the divider.
    - Restart HIGH with cnt=1.
- Timeout: if cnt reaches 2^CNT_W-1 in HIGH or LOW:
  - set timeout_o=1;
  - emit a synthetic sample: all-ones if in HIGH, 0 if in LOW;
  - go to IDLE.
  - timeout_o clears when the next complete period is captured.
- enable_i=0: go to IDLE immediately. Any in-progress count is discarded. The divider finishes, and a pending output remains until it is accepted.
- Arithmetic: sample = floor(hi * 2^SAMPLE_W / per). Since hi < per always, the result always fits in SAMPLE_W bits with no saturation.
- Divider is restoring, one quotient bit per cycle, SAMPLE_W cycles. Each iteration: r = hi initially, then r = r<<1; if r >= per then r -= per and the bit is 1. The remainder is CNT_W+1 bits wide.
- Latency: sample_valid_o rises SAMPLE_W+1 cycles after the closing rise edge is detected.
- Output handshake:
  - sample_valid_o stays high and sample_o stays stable until a cycle with sample_valid_o & sample_ready_i.
  - valid drops the cycle after acceptance unless a new result lands in that same cycle.
- Drop and overrun rules:
  - If a period completes while the divider is busy, the new measurement is dropped: high_o/period_o are not updated and overrun_o pulses.
  - If the divider finishes while the output register is full and not being accepted that cycle, the result is dropped and overrun_o pulses.
  - If both drops occur in the same cycle, overrun_o is a single one-cycle pulse.
- A timeout synthetic sample follows the same output/overrun rules.
- Minimum measurable high time and low time are each 1 cycle after synchronization.

Decomposition:
- Shared package pwm_audio_pkg holds:
  - the state enum (IDLE/HIGH/LOW);
  - the default CNT_W and SAMPLE_W constants, shared with the generator's frequency width.
- One sub-module, pwm_div_seq, is the sequential restoring divider.
  - Ports: start, num, den, busy, done, quot.
  - Parameterised by CNT_W and SAMPLE_W.
- Synchronizer, FSM and output register stay in pwm_demod.

Test Plan:
- Duty-cycle conversion, SAMPLE_W=8, ready tied 1:
  - period 256, high 64, three periods → exactly 2 samples of 64, high_o=64, period_o=256. The first rise yields nothing.
  - period 100, high 25 → sample 64.
  - period 200, high 199 → sample 254.
  - period 3, high 1 → sample 85.
- Latency: a single closing rise at pad cycle t → sample_valid_o at t+2+SAMPLE_W+1 (±1 for edge alignment). Check exact value against the model.
- Stuck input:
  - pwm_in held high for 70000 cycles after a rise → timeout_o=1 at cnt=65535, one sample 255, FSM in IDLE.
  - Restart with a normal 256/128 waveform → timeout_o clears at the first captured period; sample 128.
- Backpressure: ready=0, period 64, high 16, over 3 periods → first sample 64 held stable, overrun_o pulses once per later completed result. Raising ready accepts 64 and valid drops the next cycle.
- Short period: period 4, high 2 → each capture occurring while the divider is busy produces an overrun pulse, and high_o/period_o hold the last accepted values.
- Reset and enable:
  - reset low mid-HIGH → all outputs 0 immediately, asynchronously. After release, the first rise produces no sample.
  - enable_i low for 10 cycles mid-LOW → no sample for the interrupted period.
